// File: rtl/saturn_uart_fifo_tx.sv
// saturn_uart_fifo_tx: buffered 8N1 transmitter for the saturn_bus debug
// character stream. A small circular FIFO absorbs trace bursts; the TX FSM
// drains it one frame at a time at CLK_HZ/BAUD cycles per bit.
module saturn_uart_fifo_tx #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 115200,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            i_char,
  input  logic                  i_char_valid,
  output logic                  o_serial_busy,
  output logic                  o_serial_tx,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_overflow,
  output logic                  o_idle
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] LVL_FULL = PW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // character storage
  logic [7:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] level_reg;
  logic          overflow_reg;

  state_t        state_reg;
  logic [CW-1:0] baud_cnt_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          tx_reg;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Full/empty come from the registered level, so a pop in the same cycle
  // never lets a strobe sneak into a full FIFO.
  assign full  = (level_reg == LVL_FULL);
  assign empty = (level_reg == '0);
  assign push  = i_char_valid && !full;
  assign pop   = (state_reg == IDLE) && !empty;

  assign o_serial_busy = full;
  assign o_serial_tx   = tx_reg;
  assign o_level       = level_reg;
  assign o_overflow    = overflow_reg;
  assign o_idle        = empty && (state_reg == IDLE);

  // FIFO storage write; no reset so the array can map onto RAM
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= i_char;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + PTR_ONE;
        2'b01:   level_reg <= level_reg - PTR_ONE;
        default: level_reg <= level_reg;
      endcase
      if (i_char_valid && full) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Transmit FSM; the line is registered from the current state, so it lags
  // the state by one cycle and every bit still lasts exactly DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          tx_reg <= 1'b1;
          if (!empty) begin
            shift_reg    <= mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
            bit_idx_reg  <= '0;
            baud_cnt_reg <= '0;
            state_reg    <= START;
          end
        end
        START: begin
          tx_reg <= 1'b0;
          if (baud_cnt_reg == DIV_LAST) begin
            baud_cnt_reg <= '0;
            state_reg    <= DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CNT_ONE;
          end
        end
        DATA: begin
          tx_reg <= shift_reg[0];
          if (baud_cnt_reg == DIV_LAST) begin
            baud_cnt_reg <= '0;
            shift_reg    <= {1'b0, shift_reg[7:1]};
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CNT_ONE;
          end
        end
        STOP: begin
          tx_reg <= 1'b1;
          if (baud_cnt_reg == DIV_LAST) begin
            baud_cnt_reg <= '0;
            state_reg    <= IDLE;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CNT_ONE;
          end
        end
        default: begin
          tx_reg       <= 1'b1;
          baud_cnt_reg <= '0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_saturn_uart_fifo_tx.sv
// Testbench for saturn_uart_fifo_tx at DIV=8, 4-entry FIFO.
module tb_saturn_uart_fifo_tx;

  logic       clk;
  logic       reset;
  logic [7:0] i_char;
  logic       i_char_valid;
  logic       o_serial_busy;
  logic       o_serial_tx;
  logic [2:0] o_level;
  logic       o_overflow;
  logic       o_idle;

  saturn_uart_fifo_tx #(
    .CLK_HZ(8),
    .BAUD(1),
    .DEPTH_LOG2(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_char(i_char),
    .i_char_valid(i_char_valid),
    .o_serial_busy(o_serial_busy),
    .o_serial_tx(o_serial_tx),
    .o_level(o_level),
    .o_overflow(o_overflow),
    .o_idle(o_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int cyc;
  int rst_cnt;

  logic [7:0] tx_list[$];
  logic [7:0] exp_q[$];
  logic [9:0] rx_q[$];
  int         st_q[$];

  typedef struct {
    logic [7:0] ch;
    logic [9:0] frame;   // line bits in time order: [0]=start, [8:1]=data, [9]=stop
  } vec_t;

  vec_t vecs[4];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (reset) rst_cnt <= rst_cnt + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end else begin
      $display("check %s: got 0x%0h ok", name, got);
    end
  endtask

  // strobe every character of tx_list on consecutive edges
  task automatic send();
    for (int i = 0; i < tx_list.size(); i++) begin
      @(negedge clk);
      i_char       = tx_list[i];
      i_char_valid = 1'b1;
    end
    @(negedge clk);
    i_char_valid = 1'b0;
    tx_list.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!o_idle && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_idle"}, 32'(o_idle), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic compare_rx(input string tag);
    chk({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_frame%0d", tag, i), 32'(rx_q[i]), 32'({1'b1, exp_q[i], 1'b0}));
    end
    rx_q.delete();
    st_q.delete();
    exp_q.delete();
  endtask

  // line monitor: decodes every frame at bit centres, discards frames hit by reset
  initial begin
    logic       prev;
    logic [9:0] fr;
    int         st;
    int         rc;
    prev = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (prev && !o_serial_tx) begin
        st = cyc;
        rc = rst_cnt;
        repeat (4) @(posedge clk);
        #1;
        fr[0] = o_serial_tx;
        for (int b = 1; b < 10; b++) begin
          repeat (8) @(posedge clk);
          #1;
          fr[b] = o_serial_tx;
        end
        if (rc == rst_cnt) begin
          rx_q.push_back(fr);
          st_q.push_back(st);
        end
        prev = 1'b1;
      end else begin
        prev = o_serial_tx;
      end
    end
  end

  initial begin
    logic [9:0] got;

    vecs[0] = '{ch: 8'h41, frame: 10'b1010000010};
    vecs[1] = '{ch: 8'h01, frame: 10'b1000000010};
    vecs[2] = '{ch: 8'h80, frame: 10'b1100000000};
    vecs[3] = '{ch: 8'h7E, frame: 10'b1011111100};

    reset        = 1'b1;
    i_char       = 8'h00;
    i_char_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(o_serial_tx), 32'd1);
    chk("rst_level", 32'(o_level), 32'd0);
    chk("rst_busy", 32'(o_serial_busy), 32'd0);
    chk("rst_overflow", 32'(o_overflow), 32'd0);
    chk("rst_idle", 32'(o_idle), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single-character vectors: latency, bit-centre samples, return to idle
    for (int v = 0; v < 4; v++) begin
      tx_list.push_back(vecs[v].ch);
      exp_q.push_back(vecs[v].ch);
      send();
      chk($sformatf("v%0d_level_push", v), 32'(o_level), 32'd1);
      chk($sformatf("v%0d_busy_idle", v), 32'(o_idle), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_lat_hi", v), 32'(o_serial_tx), 32'd1);
      chk($sformatf("v%0d_level_pop", v), 32'(o_level), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_lat_lo", v), 32'(o_serial_tx), 32'd0);
      got = '0;
      repeat (4) @(posedge clk);
      #1;
      got[0] = o_serial_tx;
      for (int b = 1; b < 10; b++) begin
        repeat (8) @(posedge clk);
        #1;
        got[b] = o_serial_tx;
      end
      chk($sformatf("v%0d_frame_%02h", v, vecs[v].ch), 32'(got), 32'(vecs[v].frame));
      repeat (4) @(posedge clk);
      #1;
      chk($sformatf("v%0d_end_idle", v), 32'(o_idle), 32'd1);
      chk($sformatf("v%0d_end_level", v), 32'(o_level), 32'd0);
    end
    repeat (4) @(negedge clk);
    compare_rx("vec");

    // burst fill: 0x10..0x15 on consecutive edges; 0x15 meets a full FIFO
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) begin
        chk("burst_level_full", 32'(o_level), 32'd4);
        chk("burst_busy", 32'(o_serial_busy), 32'd1);
      end
      i_char       = 8'h10 + 8'(i);
      i_char_valid = 1'b1;
    end
    @(negedge clk);
    i_char_valid = 1'b0;
    chk("burst_overflow", 32'(o_overflow), 32'd1);
    chk("burst_level_hold", 32'(o_level), 32'd4);
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    wait_idle("burst");
    compare_rx("burst");

    // back-to-back frames
    tx_list = '{8'h55, 8'hAA};
    exp_q   = '{8'h55, 8'hAA};
    send();
    wait_idle("b2b");
    chk("b2b_gap", 32'((st_q.size() >= 2) ? (st_q[1] - st_q[0]) : 0), 32'd81);
    compare_rx("b2b");

    // write during transmission
    tx_list = '{8'h33};
    exp_q   = '{8'h33, 8'h7E};
    send();
    repeat (30) @(negedge clk);
    chk("mid_level0", 32'(o_level), 32'd0);
    tx_list = '{8'h7E};
    send();
    chk("mid_level1", 32'(o_level), 32'd1);
    wait_idle("mid");
    chk("mid_gap", 32'((st_q.size() >= 2) ? (st_q[1] - st_q[0]) : 0), 32'd81);
    compare_rx("mid");

    // reset during data bit 3
    chk("ovf_before_reset", 32'(o_overflow), 32'd1);
    tx_list = '{8'h41};
    send();
    repeat (36) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_tx", 32'(o_serial_tx), 32'd1);
    chk("mrst_level", 32'(o_level), 32'd0);
    chk("mrst_overflow", 32'(o_overflow), 32'd0);
    chk("mrst_idle", 32'(o_idle), 32'd1);
    repeat (60) @(negedge clk);
    tx_list = '{8'h01};
    exp_q   = '{8'h01};
    send();
    wait_idle("mrst");
    compare_rx("mrst");

    // pointer wrap: 10 characters in groups of 3
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 3 && g * 3 + k < 10; k++) begin
        tx_list.push_back(8'hA0 + 8'(g * 3 + k));
        exp_q.push_back(8'hA0 + 8'(g * 3 + k));
      end
      send();
      wait_idle($sformatf("wrap_g%0d", g));
    end
    compare_rx("wrap");
    chk("wrap_overflow", 32'(o_overflow), 32'd0);
    chk("wrap_level", 32'(o_level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/saturn_uart_fifo_tx.md
Name: saturn_uart_fifo_tx

Overview:
Buffered 8N1 serial transmitter for the debug character stream that saturn_bus emits (o_char_to_send / o_char_valid). Sits directly downstream of the bus and drives the FTDI RX pin. A character FIFO decouples bus trace bursts from line rate. Back-pressure to the bus is a single busy flag wired to the bus's i_serial_busy.

Parameters:
CLK_HZ, 25000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s; DIV = CLK_HZ/BAUD (integer floor), must be >= 2
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
i_char  in  8  character from bus
i_char_valid  in  1  one-cycle write strobe
o_serial_busy  out  1  FIFO full; bus must not strobe while high
o_serial_tx  out  1  serial line, idle high, registered
o_level  out  DEPTH_LOG2+1  FIFO occupancy 0..DEPTH
o_overflow  out  1  sticky: a strobe arrived while full
o_idle  out  1  FIFO empty and transmitter in IDLE

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk. No other clock enable. All state updates on posedge clk.
- Reset values: o_serial_tx=1, o_level=0, o_serial_busy=0, o_overflow=0, o_idle=1, FSM=IDLE, baud counter=0, read/write pointers=0.
- Reset mid-frame: frame aborted, line high the cycle after reset is sampled, FIFO contents discarded.
- FIFO: circular buffer, pointers DEPTH_LOG2+1 bits wide, wrap modulo 2*DEPTH. Full = level==DEPTH; empty = level==0. o_serial_busy = full, driven from registered level.
- Write: i_char_valid && !full pushes i_char. o_level reflects the push on the next cycle.
- Write while full: the character is dropped and o_overflow is set. This holds even if a pop occurs in the same cycle; full is evaluated on pre-edge state. o_overflow clears only on reset.
- Simultaneous push and pop when not full: level unchanged, both take effect.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO not empty, pop the head into an 8-bit shift register, set bit index=0 and baud counter=0, go to START. Otherwise stay; tx=1.
  - START: tx=0 for DIV cycles, then DATA.
  - DATA: tx=shift[0] for DIV cycles per bit, shifting right after each bit, LSB first. After 8 bits go to STOP.
  - STOP: tx=1 for DIV cycles, then IDLE.
- Baud counter: counts 0..DIV-1; the terminal count advances the bit. Width is clog2(DIV).
- Latency: strobe at edge N, FSM pops at edge N+1, o_serial_tx first low after edge N+2.
- Frame timing: one frame = 10*DIV cycles low-to-end-of-stop. Back-to-back frames are separated by exactly 1 extra high cycle (the IDLE visit), so start bits are 10*DIV+1 cycles apart.
- o_idle = empty && state==IDLE, registered-consistent with o_level.
- o_level never exceeds DEPTH and never underflows. A pop is only issued when not empty.

Test Plan:
- Single character: CLK_HZ=8, BAUD=1 (DIV=8). Write 0x41 at edge 0 -> tx low from edge 2 for 8 cycles. Data bits 1,0,0,0,0,0,1,0 at 8 cycles each, then high for 8 cycles. o_idle returns to 1 at frame end +1. o_level goes 0→1→0.
- Burst fill: DEPTH_LOG2=2, DIV=8. Strobe 0x10..0x15 on consecutive cycles -> o_serial_busy=1 once level=4, later strobes dropped, o_overflow=1. Line emits exactly 0x10, then the chars the FIFO accepted while the first pop freed a slot, each in order. No duplicate or corrupted bytes.
- Back-to-back: queue 0x55 and 0xAA -> start bits 81 cycles apart at DIV=8, correct LSB-first patterns, stop bits high.
- Write during transmission: push 0x7E mid-DATA of an earlier frame -> o_level increments, 0x7E is sent next, in-flight frame is unaffected.
- Reset mid-frame: assert reset during DATA bit 3 for 1 cycle -> tx=1, o_level=0, o_overflow=0, o_idle=1 on the next cycle. A new write of 0x01 then transmits normally.
- Pointer wrap: DEPTH_LOG2=2; push and drain 10 characters in groups of 3 -> every character is transmitted in order, o_overflow stays 0, level returns to 0.
